// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, control bundle, helpers.
package hazard_ctrl_pkg;

   localparam int unsigned RegAddrW = 5;

   typedef logic [RegAddrW-1:0] reg_addr_t;

   // Encoding is visible on the debug state port, so values are pinned.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StMduWait = 2'd1
   } hazard_state_e;

   // One bit per pipeline-register enable/clear driven by the controller.
   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic flush_id;
      logic flush_ex;
      logic bubble_mem;
   } hazard_ctrl_t;

   localparam hazard_ctrl_t CtrlNone = '0;

   // Wrong-path squash of IF/ID and ID/EX; fetch continues from the new PC.
   localparam hazard_ctrl_t CtrlRedirect = '{
      stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
      flush_id: 1'b1, flush_ex: 1'b1, bubble_mem: 1'b0
   };

   // Hold the consumer in ID for one cycle and inject a bubble behind the load.
   localparam hazard_ctrl_t CtrlLoadUse = '{
      stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0,
      flush_id: 1'b0, flush_ex: 1'b1, bubble_mem: 1'b0
   };

   // MDU occupies EX: freeze the front end and EX, feed bubbles into MEM.
   localparam hazard_ctrl_t CtrlMduHold = '{
      stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
      flush_id: 1'b0, flush_ex: 1'b0, bubble_mem: 1'b1
   };

   // Last MDU cycle: front end still held, the MDU op advances into MEM.
   localparam hazard_ctrl_t CtrlMduRelease = '{
      stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0,
      flush_id: 1'b0, flush_ex: 1'b0, bubble_mem: 1'b0
   };

   // A source only depends on a producer when it is actually read and rd is not x0.
   function automatic logic src_hit(logic used, reg_addr_t rs, reg_addr_t rd);
      return used && (rd != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);

   // Pipeline-side hazard sources
   hazard_ctrl_pkg::reg_addr_t rs1_id;
   hazard_ctrl_pkg::reg_addr_t rs2_id;
   logic                       rs1_used_id;
   logic                       rs2_used_id;
   hazard_ctrl_pkg::reg_addr_t rd_ex;
   logic                       reg_wr_en_ex;
   logic                       mem_rd_ex;
   logic                       mdu_start_ex;
   logic                       mdu_done;
   logic                       branch_taken_ex;

   // Controller-side pipeline-register enables/clears and status
   logic                       stall_if;
   logic                       stall_id;
   logic                       stall_ex;
   logic                       flush_id;
   logic                       flush_ex;
   logic                       bubble_mem;
   logic [1:0]                 state;
   logic                       mdu_timeout;
   logic [CNT_W-1:0]           stall_cycles;

   modport master (
      output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, reg_wr_en_ex,
      output mem_rd_ex, mdu_start_ex, mdu_done, branch_taken_ex,
      input  stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem,
      input  state, mdu_timeout, stall_cycles
   );

   modport slave (
      input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, reg_wr_en_ex,
      input  mem_rd_ex, mdu_start_ex, mdu_done, branch_taken_ex,
      output stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem,
      output state, mdu_timeout, stall_cycles
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush side of hazard resolution: load-use bubble, MDU occupancy with
// watchdog, and branch redirect flush. Also counts front-end stall cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MDU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   // Watchdog counts 1..MDU_TIMEOUT-1 while waiting, so clog2 bits suffice.
   localparam int unsigned     WdW    = $clog2(MDU_TIMEOUT);
   localparam logic [WdW-1:0]  WdLast = WdW'(MDU_TIMEOUT - 1);

   hazard_state_e    r_state;
   hazard_state_e    w_state_d;
   logic [WdW-1:0]   r_wd_cnt;
   logic [WdW-1:0]   w_wd_cnt_d;
   logic             r_mdu_timeout;
   logic [CNT_W-1:0] r_stall_cycles;

   logic             w_load_use;
   logic             w_mdu_req;
   logic             w_wd_expire;
   logic             w_mdu_release;
   hazard_ctrl_t     w_ctrl;

   // Hazard detection shared by next-state and output logic
   always_comb begin
      w_load_use = hz.mem_rd_ex && hz.reg_wr_en_ex &&
                   (src_hit(hz.rs1_used_id, hz.rs1_id, hz.rd_ex) ||
                    src_hit(hz.rs2_used_id, hz.rs2_id, hz.rd_ex));
      // A result ready in the first EX cycle needs no stall at all.
      w_mdu_req     = hz.mdu_start_ex && !hz.mdu_done;
      w_wd_expire   = (r_state == StMduWait) && !hz.mdu_done && (r_wd_cnt == WdLast);
      w_mdu_release = (r_state == StMduWait) && (hz.mdu_done || w_wd_expire);
   end

   // State and watchdog registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_wd_cnt <= '0;
      end else begin
         r_state  <= w_state_d;
         r_wd_cnt <= w_wd_cnt_d;
      end
   end

   // Next state: enter MDU_WAIT on an unfinished MDU op, leave on done or watchdog
   always_comb begin
      w_state_d  = r_state;
      w_wd_cnt_d = r_wd_cnt;
      unique case (r_state)
         StIdle: begin
            // Redirect has priority; an MDU op in EX alongside it is impossible.
            if (!hz.branch_taken_ex && w_mdu_req) begin
               w_state_d  = StMduWait;
               w_wd_cnt_d = WdW'(1);
            end
         end
         StMduWait: begin
            if (w_mdu_release) begin
               w_state_d  = StIdle;
               w_wd_cnt_d = '0;
            end else begin
               w_wd_cnt_d = r_wd_cnt + WdW'(1);
            end
         end
         default: begin
            w_state_d  = StIdle;
            w_wd_cnt_d = '0;
         end
      endcase
   end

   // Outputs: pipeline enables/clears, forced quiet while reset is asserted
   always_comb begin
      w_ctrl = CtrlNone;
      if (rst_n) begin
         unique case (r_state)
            StIdle: begin
               if (hz.branch_taken_ex) begin
                  w_ctrl = CtrlRedirect;
               end else if (w_mdu_req) begin
                  w_ctrl = CtrlMduHold;
               end else if (w_load_use) begin
                  w_ctrl = CtrlLoadUse;
               end
            end
            StMduWait: begin
               w_ctrl = w_mdu_release ? CtrlMduRelease : CtrlMduHold;
            end
            default: w_ctrl = CtrlNone;
         endcase
      end
   end

   // Sticky watchdog flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mdu_timeout <= 1'b0;
      end else if (w_wd_expire) begin
         r_mdu_timeout <= 1'b1;
      end
   end

   // Stall-cycle performance counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (w_ctrl.stall_if) begin
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign hz.stall_if     = w_ctrl.stall_if;
   assign hz.stall_id     = w_ctrl.stall_id;
   assign hz.stall_ex     = w_ctrl.stall_ex;
   assign hz.flush_id     = w_ctrl.flush_id;
   assign hz.flush_ex     = w_ctrl.flush_ex;
   assign hz.bubble_mem   = w_ctrl.bubble_mem;
   assign hz.state        = r_state;
   assign hz.mdu_timeout  = r_mdu_timeout;
   assign hz.stall_cycles = r_stall_cycles;

   // EX holds the MDU op while waiting, so it cannot be redirecting.
   a_no_branch_in_mdu_wait: assert property (
      @(posedge clk) disable iff (!rst_n) (r_state == StMduWait) |-> !hz.branch_taken_ex
   );

   // One instruction in EX cannot be both an MDU op and a taken branch.
   a_start_branch_excl: assert property (
      @(posedge clk) disable iff (!rst_n) !(hz.mdu_start_ex && hz.branch_taken_ex)
   );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the RV32 5-stage core: the stall/flush side of hazard resolution, complementing operand forwarding. It handles the hazards forwarding cannot cover:
- load-use (one bubble),
- multi-cycle MUL/DIV occupancy of EX (FSM-held stall with watchdog),
- taken-branch/jump redirect (wrong-path flush).
It drives pipeline-register enables and clears, and keeps a stall-cycle performance counter.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before watchdog fires (≥2)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  core clock; reset is asynchronous and active-low
rst_n  in  1  asynchronous active-low reset
rs1_id  in  5  rs1 of instruction in ID
rs2_id  in  5  rs2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  5  rd of instruction in EX
reg_wr_en_ex  in  1  EX instruction writes rd
mem_rd_ex  in  1  EX instruction is a load
mdu_start_ex  in  1  EX instruction is MUL/DIV, first cycle in EX
mdu_done  in  1  MDU result valid this cycle
branch_taken_ex  in  1  EX redirects PC this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
flush_id  out  1  clear IF/ID register (NOP)
flush_ex  out  1  clear ID/EX register (bubble into EX)
bubble_mem  out  1  clear EX/MEM register (bubble into MEM)
state  out  2  hazardState_e, debug
mdu_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  count of cycles with stall_if=1, wraps

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, watchdog counter=0, mdu_timeout=0, stall_cycles=0.
- All stall/flush outputs are 0 while in reset.

FSM states (hazardState_e): IDLE=0, MDU_WAIT=1. Stall/flush outputs are combinational from state and inputs.

IDLE, priority order:
1. branch_taken_ex: flush_id=1, flush_ex=1, no stall. Branch wins over a simultaneous load-use hazard, because the ID instruction is wrong-path. Stay IDLE.
2. mdu_start_ex && !mdu_done: stall_if=stall_id=stall_ex=1, bubble_mem=1. Next state MDU_WAIT, watchdog counter ←1. If mdu_done is in the same cycle, there is no stall and the state stays IDLE.
3. Load-use: mem_rd_ex && reg_wr_en_ex && rd_ex≠0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
   - Outputs: stall_if=stall_id=1, flush_ex=1.
   - Lasts exactly one cycle; the load then reaches MEM and forwarding covers the dependency.
4. Otherwise all outputs 0.

MDU_WAIT:
- stall_if=stall_id=stall_ex=bubble_mem=1 every cycle. mdu_start_ex is ignored, since the held instruction re-presents it.
- mdu_done=1: outputs are still asserted that cycle (the result is captured into EX/MEM at the clock edge, with bubble_mem deasserted at the edge logic). Next state IDLE, counter ←0.
- Precise rule for the done cycle: in MDU_WAIT with mdu_done=1, stall_if=stall_id=1 and stall_ex=0, bubble_mem=0, so the MDU instruction advances.
- Counter increments each cycle. On counter==MDU_TIMEOUT-1 without done: mdu_timeout←1 (sticky until reset), next state IDLE, outputs as in the done cycle.
- branch_taken_ex cannot occur in MDU_WAIT, because EX holds the MDU op. This is an assertion.

stall_cycles: +1 on every cycle with stall_if=1; wraps modulo 2^CNT_W.

mdu_start_ex and branch_taken_ex are mutually exclusive (assertion).

x0 is never a hazard source.

Decomposition:
- types.svh: add hazardState_e (2-bit enum: IDLE, MDU_WAIT); reuse the existing package include.
- No sub-module. Load-use detection and the FSM stay in one module.
- The stall counter is an inline always_ff.

Test Plan:
- Load-use: lw x5 in EX (mem_rd_ex=1, rd_ex=5, reg_wr_en_ex=1) with rs2_id=5, rs2_used_id=1 → stall_if=stall_id=flush_ex=1 for exactly 1 cycle; stall_cycles 0→1. Repeat with rd_ex=0 → no stall.
- Branch beats load-use: same load-use inputs plus branch_taken_ex=1 → flush_id=flush_ex=1, stall_if=0, stall_cycles unchanged.
- MDU 4-cycle: mdu_start_ex=1 at cycle 0, mdu_done=1 at cycle 3 → stall_ex=bubble_mem=1 on cycles 0–2, 0 on cycle 3; state IDLE at cycle 4; stall_cycles=4.
- MDU zero-wait: mdu_start_ex=1 and mdu_done=1 same cycle → no outputs asserted, state stays IDLE.
- Watchdog: MDU_TIMEOUT=8, mdu_start_ex without done → state returns IDLE after 8 cycles, mdu_timeout=1 and stays 1 until rst_n=0.
- Async reset mid-MDU_WAIT: drop rst_n between clock edges → state=IDLE and all outputs 0 immediately; counter and mdu_timeout cleared.
